// File: rtl/jmp_seq_if.sv
// jmp_seq_if: operand read bus between the jump sequencer and memory
interface jmp_seq_if;
    logic        mem_req;
    logic [22:0] mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
    modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/jmp_seq.sv
// jmp_seq: fetches jump operands, drives the jump unit and loads the next PC
module jmp_seq (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             long_mode,
    input  logic [22:0]      pc_base,
    input  logic             flush,
    jmp_seq_if.master        mem,
    output logic [15:0]      databus_out,
    output logic             highbits_we,
    output logic             jmp_oe,
    output logic [22:0]      jmp_pcin,
    input  logic             pcoe,
    input  logic [22:0]      pcout,
    output logic             pc_load,
    output logic [22:0]      pc_next,
    output logic             busy,
    output logic             taken
);
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        FETCH_HI = 3'd1,
        WRITE_HI = 3'd2,
        FETCH_LO = 3'd3,
        EXEC     = 3'd4,
        DONE     = 3'd5
    } state_t;
    state_t state, nxt;
    logic [22:0] base;
    logic        long_r;
    logic [15:0] hi_reg, lo_reg;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= nxt;
    end
    always_comb begin
        nxt = state;
        case (state)
            IDLE:     nxt = start ? (long_mode ? FETCH_HI : FETCH_LO) : IDLE;
            FETCH_HI: nxt = mem.mem_ack ? WRITE_HI : FETCH_HI;
            WRITE_HI: nxt = FETCH_LO;
            FETCH_LO: nxt = mem.mem_ack ? EXEC : FETCH_LO;
            EXEC:     nxt = DONE;
            default:  nxt = IDLE;
        endcase
        if (flush) nxt = IDLE;
    end
    always_comb begin
        busy         = state != IDLE;
        mem.mem_req  = state == FETCH_HI || state == FETCH_LO;
        mem.mem_addr = state == FETCH_HI ? base + 23'd1 :
                       state == FETCH_LO ? base + (long_r ? 23'd2 : 23'd1) : '0;
        highbits_we  = state == WRITE_HI;
        jmp_oe       = state == EXEC;
        pc_load      = state == DONE;
        databus_out  = state == WRITE_HI ? hi_reg : state == EXEC ? lo_reg : '0;
        jmp_pcin     = base;
    end
    // flush freezes every datapath register, so an aborted EXEC keeps taken/pc_next
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base    <= '0;
            long_r  <= 1'b0;
            hi_reg  <= '0;
            lo_reg  <= '0;
            taken   <= 1'b0;
            pc_next <= '0;
        end else if (!flush) begin
            if (state == IDLE && start) begin
                base   <= pc_base;
                long_r <= long_mode;
            end
            if (state == FETCH_HI && mem.mem_ack) hi_reg <= mem.mem_rdata;
            if (state == FETCH_LO && mem.mem_ack) lo_reg <= mem.mem_rdata;
            if (state == EXEC) begin
                taken   <= pcoe;
                pc_next <= pcoe ? pcout : base + (long_r ? 23'd3 : 23'd2);
            end
        end
    end
endmodule

// File: doc/jmp_seq.md
JMP_SEQ -- requirements
Module: jmp_seq

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst_n  in  1  asynchronous, active-low reset; one clock; asserting it clears all state immediately, release is synchronous to clk.
REQ-003 start  in  1  one-cycle pulse: decoded jump opcode present; sampled only in IDLE.
REQ-004 long_mode  in  1  1 = two operand words (high then low), 0 = one operand word (low only); sampled with start.
REQ-005 pc_base  in  23  address of the jump opcode; sampled with start.
REQ-006 flush  in  1  synchronous abort; returns FSM to IDLE next edge from any state.
REQ-007 mem_req  out  1  operand read request; held high until mem_ack.
REQ-008 mem_addr  out  23  operand address; stable while mem_req high.
REQ-009 mem_ack  in  1  read complete; mem_rdata valid in the same cycle.
REQ-010 mem_rdata  in  16  operand word.
REQ-011 databus_out  out  16  operand value driven to the jump unit databus.
REQ-012 highbits_we  out  1  one-cycle write strobe for the jump unit high-bits register.
REQ-013 jmp_oe  out  1  evaluate strobe to the jump unit.
REQ-014 jmp_pcin  out  23  base PC for relative targets; equals latched pc_base.
REQ-015 pcoe  in  1  jump unit: condition true.
REQ-016 pcout  in  23  jump unit: target address.
REQ-017 pc_load  out  1  one-cycle strobe: pc_next valid, load PC.
REQ-018 pc_next  out  23  next PC value.
REQ-019 busy  out  1  high in every state except IDLE.
REQ-020 taken  out  1  latched pcoe result of last completed jump; valid with pc_load, held until next EXEC.

Function
REQ-021 States SHALL be IDLE, FETCH_HI, WRITE_HI, FETCH_LO, EXEC, DONE; 3-bit encoding.
REQ-022 IDLE + start: latch pc_base, long_mode; go FETCH_HI if long_mode else FETCH_LO; start outside IDLE ignored.
REQ-023 FETCH_HI: mem_req=1, mem_addr=pc_base+1; on mem_ack latch mem_rdata into hi_reg, go WRITE_HI.
REQ-024 WRITE_HI: exactly one cycle, highbits_we=1, databus_out=hi_reg; go FETCH_LO.
REQ-025 FETCH_LO: mem_req=1, mem_addr=pc_base+1 (short) or pc_base+2 (long); on mem_ack latch mem_rdata into lo_reg, go EXEC.
REQ-026 EXEC: exactly one cycle, jmp_oe=1, databus_out=lo_reg; register taken<=pcoe; pc_next reg <= pcout if pcoe else pc_base+2 (short) or pc_base+3 (long); go DONE.
REQ-027 DONE: pc_load=1 for one cycle; go IDLE; new start accepted no earlier than the following IDLE cycle.
REQ-028 All address arithmetic SHALL be 23-bit modulo 2^23 (pc_base=0x7FFFFF, short: operand at 0x000000, fall-through 0x000001).
REQ-029 Wait states: mem_req and mem_addr SHALL stay stable for any number of cycles until mem_ack; mem_ack outside FETCH_HI/FETCH_LO ignored.
REQ-030 Zero-wait latency from start to pc_load: long 5 cycles, short 3 cycles.
REQ-031 databus_out SHALL be 0 in all states other than WRITE_HI and EXEC; highbits_we, jmp_oe, mem_req, pc_load SHALL be 0 outside their named states.
REQ-032 flush has priority over start, mem_ack and all transitions; flush in EXEC suppresses DONE/pc_load; taken and pc_next keep prior values; highbits already written are not undone.
REQ-033 Simultaneous flush and mem_ack: data discarded, no highbits_we.

Reset
REQ-034 On rst_n low: state=IDLE; busy, mem_req, highbits_we, jmp_oe, pc_load, taken=0; mem_addr, databus_out, jmp_pcin, pc_next, hi_reg, lo_reg=0.
REQ-035 Reset mid-operation SHALL abandon the transaction with no further strobes after release; first start after release behaves as from power-up.

Verification
REQ-036 Long, zero-wait: start, pc_base=0x000100, rdata 0x0012 then 0x3456, pcoe=1, pcout=0x123456 -> highbits_we cycle 2 with 0x0012, jmp_oe cycle 4 with 0x3456, pc_load cycle 5, pc_next=0x123456, taken=1.
REQ-037 Short not taken: pc_base=0x000200, rdata 0x0040, pcoe=0 -> no highbits_we, mem_addr 0x000201, pc_load cycle 3, pc_next=0x000202, taken=0.
REQ-038 Wait states: mem_ack delayed 3 cycles in each fetch -> mem_req/mem_addr stable throughout, long latency 11 cycles.
REQ-039 Wrap: short, pc_base=0x7FFFFF, pcoe=0 -> mem_addr 0x000000, pc_next=0x000001.
REQ-040 flush asserted in WRITE_HI, then start in next IDLE -> no pc_load for first jump; second jump completes normally.
REQ-041 rst_n low during FETCH_LO with mem_ack high -> all outputs per REQ-034 immediately; no pc_load after release.
